// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Conditions the raw push-buttons (reset, hit, stay) ahead of the game logic.
// Each channel has a 2-FF synchronizer, a debounce FSM, registered one-cycle
// press (fall) and release (rise) pulses, and a one-shot long-press pulse.
// All channels are identical and fully independent.
//
// Parameters
//   N_BTN        number of button channels (bit 0 = reset key)
//   DEB_CYCLES   consecutive stable samples needed to accept a change (>= 2)
//   HOLD_CYCLES  cycles after an accepted press before o_Hold fires
//                (> DEB_CYCLES)
//
// Ports
//   clk_2K    in   2 kHz clock, all logic on the rising edge
//   i_Rst_n   in   asynchronous active-low reset
//   i_Btn     in   raw key pins, async, pulled up (1 = released, 0 = pressed)
//   o_Level   out  debounced level (1 = released, 0 = pressed)
//   o_Fall    out  one-cycle pulse on accepted press
//   o_Rise    out  one-cycle pulse on accepted release
//   o_Hold    out  one-cycle pulse, once per press, after HOLD_CYCLES
//   o_State   out  debug view of every channel's FSM state,
//                  channel g at bits [2*g+1 : 2*g]
//                  (0 = REL, 1 = CHK_PRESS, 2 = PRS, 3 = CHK_REL)
//
// Every output is a flop; there is no combinational path from input to
// output. There is no valid/ready handshake on this block: inputs are
// free-running pin levels and outputs are level/pulse strobes.
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN       = 3,
  parameter int DEB_CYCLES  = 40,
  parameter int HOLD_CYCLES = 4000
) (
  input  logic               clk_2K,
  input  logic               i_Rst_n,
  input  logic [N_BTN-1:0]   i_Btn,
  output logic [N_BTN-1:0]   o_Level,
  output logic [N_BTN-1:0]   o_Fall,
  output logic [N_BTN-1:0]   o_Rise,
  output logic [N_BTN-1:0]   o_Hold,
  output logic [2*N_BTN-1:0] o_State
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] C_DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] C_HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    REL       = 2'd0,
    CHK_PRESS = 2'd1,
    PRS       = 2'd2,
    CHK_REL   = 2'd3
  } state_t;

  // Synchronizer resets to "released" so a reset never looks like a press.
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge clk_2K or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_Btn;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_cnt_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          r_fall;
    logic          w_fall_nxt;
    logic          r_rise;
    logic          w_rise_nxt;
    logic          r_holdp;
    logic          w_holdp_nxt;
    logic          w_s;

    assign w_s = r_sync2[g];

    always_ff @(posedge clk_2K or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        r_state <= REL;
        r_cnt   <= '0;
        r_hold  <= '0;
        r_level <= 1'b1;
        r_fall  <= 1'b0;
        r_rise  <= 1'b0;
        r_holdp <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_hold  <= w_hold_nxt;
        r_level <= w_level_nxt;
        r_fall  <= w_fall_nxt;
        r_rise  <= w_rise_nxt;
        r_holdp <= w_holdp_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_hold_nxt  = r_hold;
      w_level_nxt = r_level;
      w_fall_nxt  = 1'b0;
      w_rise_nxt  = 1'b0;
      w_holdp_nxt = 1'b0;

      case (r_state)
        REL: begin
          if (!w_s) begin
            w_state_nxt = CHK_PRESS;
            w_cnt_nxt   = DW'(1);
          end
        end

        CHK_PRESS: begin
          if (w_s) begin
            // Bounce: drop the candidate without touching the outputs.
            w_state_nxt = REL;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_DEB_LAST) begin
            w_state_nxt = PRS;
            w_level_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_hold_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + DW'(1);
          end
        end

        PRS: begin
          // The hold counter advances on every PRS edge, including the one
          // that leaves for CHK_REL; it stops only while a release is being
          // qualified, so a short release glitch delays o_Hold by exactly
          // the glitch length.
          if (r_hold != C_HOLD_MAX) begin
            w_hold_nxt = r_hold + HW'(1);
          end
          if (r_hold == C_HOLD_LAST) begin
            w_holdp_nxt = 1'b1;
          end
          if (w_s) begin
            w_state_nxt = CHK_REL;
            w_cnt_nxt   = DW'(1);
          end
        end

        CHK_REL: begin
          if (!w_s) begin
            w_state_nxt = PRS;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_DEB_LAST) begin
            w_state_nxt = REL;
            w_level_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_hold_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + DW'(1);
          end
        end

        default: begin
          w_state_nxt = REL;
          w_cnt_nxt   = '0;
          w_hold_nxt  = '0;
          w_level_nxt = 1'b1;
        end
      endcase
    end

    assign o_Level[g]       = r_level;
    assign o_Fall[g]        = r_fall;
    assign o_Rise[g]        = r_rise;
    assign o_Hold[g]        = r_holdp;
    assign o_State[2*g +: 2] = r_state;
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int NB   = 3;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int W    = 4 * NB;

  // ---------------- clock / reset ----------------
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn   = '0;
  logic [NB-1:0] o_level;
  logic [NB-1:0] o_fall;
  logic [NB-1:0] o_rise;
  logic [NB-1:0] o_hold;
  logic [2*NB-1:0] o_state;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN      (NB),
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_2K  (clk),
    .i_Rst_n (rst_n),
    .i_Btn   (btn),
    .o_Level (o_level),
    .o_Fall  (o_fall),
    .o_Rise  (o_rise),
    .o_Hold  (o_hold),
    .o_State (o_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // A channel toggles its accepted level once the synchronized pin has
  // disagreed with it for DEB consecutive samples. The long-press age
  // accumulates on edges where the key is accepted as pressed and no
  // release candidate is pending, and fires once when it reaches HOLD.
  logic [W-1:0]  exp_q[$];
  logic [NB-1:0] m_sync1 = '1;
  logic [NB-1:0] m_sync2 = '1;
  logic [NB-1:0] m_level = '1;
  logic [NB-1:0] m_s, m_f, m_r, m_h;
  int            m_run[NB];
  int            m_age[NB];

  initial begin
    for (int i = 0; i < NB; i++) begin
      m_run[i] = 0;
      m_age[i] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync1 = '1;
      m_sync2 = '1;
      m_level = '1;
      for (int i = 0; i < NB; i++) begin
        m_run[i] = 0;
        m_age[i] = 0;
      end
      exp_q.delete();
    end else begin
      m_s     = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = btn;
      m_f = '0;
      m_r = '0;
      m_h = '0;
      for (int i = 0; i < NB; i++) begin
        if (m_level[i] == 1'b0 && m_run[i] == 0 && m_age[i] < HOLD) begin
          m_age[i] = m_age[i] + 1;
          if (m_age[i] == HOLD) m_h[i] = 1'b1;
        end
        if (m_s[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_level[i] = m_s[i];
            if (m_s[i]) m_r[i] = 1'b1;
            else        m_f[i] = 1'b1;
            m_run[i] = 0;
            m_age[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      exp_q.push_back({m_level, m_f, m_r, m_h});
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] sb_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: got empty queue at %0t, required one entry", $time);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({o_level, o_fall, o_rise, o_hold} !== sb_exp) begin
          n_err++;
          $display("FAIL sb_cycle @%0t: got lvl/fall/rise/hold=%b_%b_%b_%b required %b_%b_%b_%b",
                   $time, o_level, o_fall, o_rise, o_hold,
                   sb_exp[4*NB-1 -: NB], sb_exp[3*NB-1 -: NB],
                   sb_exp[2*NB-1 -: NB], sb_exp[NB-1 -: NB]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 3'b000;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (o_level !== 3'b111) begin
        n_err++;
        $display("FAIL reset_level: got %b required 111", o_level);
      end
      n_vec++;
      if ((o_fall | o_rise | o_hold) !== 3'b000) begin
        n_err++;
        $display("FAIL reset_pulses: got fall=%b rise=%b hold=%b required 000", o_fall, o_rise, o_hold);
      end
    end
    btn   = 3'b111;
    rst_n = 1'b1;
    idle(6);
  endtask

  task automatic test_clean_press();
    int first_f, n_f, first_r, n_r, n_h;
    first_f = -1; n_f = 0; n_h = 0;
    btn[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_fall[1]) begin n_f++; if (first_f < 0) first_f = k; end
      if (o_hold[1]) n_h++;
    end
    n_vec++;
    if (first_f != DEB + 1 || n_f != 1) begin
      n_err++;
      $display("FAIL press_fall: got first=%0d count=%0d required first=%0d count=1", first_f, n_f, DEB + 1);
    end
    n_vec++;
    if (o_level[1] !== 1'b0) begin
      n_err++;
      $display("FAIL press_level: got %b required 0", o_level[1]);
    end
    first_r = -1; n_r = 0; n_f = 0;
    btn[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_rise[1]) begin n_r++; if (first_r < 0) first_r = k; end
      if (o_fall[1]) n_f++;
      if (o_hold[1]) n_h++;
    end
    n_vec++;
    if (first_r != DEB + 1 || n_r != 1 || n_f != 0) begin
      n_err++;
      $display("FAIL release_rise: got first=%0d rise=%0d fall=%0d required first=%0d rise=1 fall=0",
               first_r, n_r, n_f, DEB + 1);
    end
    n_vec++;
    if (n_h != 0 || o_level[1] !== 1'b1) begin
      n_err++;
      $display("FAIL short_press_state: got hold=%0d level=%b required hold=0 level=1", n_h, o_level[1]);
    end
  endtask

  task automatic test_bounce();
    logic [0:6] pat;
    int bad, first_f, n_f;
    pat = 7'b0001001;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      btn[0] = (k < 7) ? pat[k] : 1'b1;
      tick();
      if (o_level[0] !== 1'b1 || o_fall[0] || o_rise[0] || o_hold[0]) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bounce_reject: got %0d disturbed cycles required 0", bad);
    end
    first_f = -1; n_f = 0;
    btn[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_fall[0]) begin n_f++; if (first_f < 0) first_f = k; end
    end
    n_vec++;
    if (first_f != DEB + 1 || n_f != 1) begin
      n_err++;
      $display("FAIL bounce_accept: got first=%0d count=%0d required first=%0d count=1", first_f, n_f, DEB + 1);
    end
    btn[0] = 1'b1;
    idle(10);
  endtask

  task automatic test_long_press(input logic glitch);
    int first_f, n_f, first_h, n_h, n_r, want_h;
    first_f = -1; n_f = 0; first_h = -1; n_h = 0; n_r = 0;
    want_h = DEB + 1 + HOLD + (glitch ? 2 : 0);
    btn[2] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_fall[2]) begin n_f++; if (first_f < 0) first_f = k; end
      if (o_hold[2]) begin n_h++; if (first_h < 0) first_h = k; end
      if (o_rise[2]) n_r++;
      // Two raw-high samples while the hold age sits at 5.
      btn[2] = (glitch && (k == 8 || k == 9)) ? 1'b1 : 1'b0;
    end
    n_vec++;
    if (first_f != DEB + 1 || n_f != 1 || n_r != 0) begin
      n_err++;
      $display("FAIL long_fall g=%0b: got first=%0d fall=%0d rise=%0d required first=%0d fall=1 rise=0",
               glitch, first_f, n_f, n_r, DEB + 1);
    end
    n_vec++;
    if (first_h != want_h || n_h != 1) begin
      n_err++;
      $display("FAIL long_hold g=%0b: got first=%0d count=%0d required first=%0d count=1",
               glitch, first_h, n_h, want_h);
    end
    btn[2] = 1'b1;
    idle(10);
  endtask

  task automatic test_reset_mid_press();
    int first_f, n_f;
    btn[0] = 1'b0;
    idle(8);
    n_vec++;
    if (o_level[0] !== 1'b0) begin
      n_err++;
      $display("FAIL mid_pre_level: got %b required 0", o_level[0]);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_level !== 3'b111 || o_fall !== 3'b000) begin
      n_err++;
      $display("FAIL mid_async_reset: got level=%b fall=%b required level=111 fall=000", o_level, o_fall);
    end
    tick();
    rst_n = 1'b1;
    first_f = -1; n_f = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_fall[0]) begin n_f++; if (first_f < 0) first_f = k; end
    end
    n_vec++;
    if (first_f != DEB + 1 || n_f != 1) begin
      n_err++;
      $display("FAIL mid_refall: got first=%0d count=%0d required first=%0d count=1", first_f, n_f, DEB + 1);
    end
    btn[0] = 1'b1;
    idle(10);
  endtask

  task automatic test_simultaneous();
    int first_f, l1_bad;
    first_f = -1; l1_bad = 0;
    btn = 3'b010;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_fall !== 3'b000 && first_f < 0) begin
        first_f = k;
        n_vec++;
        if (o_fall !== 3'b101) begin
          n_err++;
          $display("FAIL simul_fall_vec: got %b required 101", o_fall);
        end
      end
      if (o_level[1] !== 1'b1) l1_bad++;
    end
    n_vec++;
    if (first_f != DEB + 1 || l1_bad != 0) begin
      n_err++;
      $display("FAIL simul_timing: got first=%0d lvl1_bad=%0d required first=%0d lvl1_bad=0",
               first_f, l1_bad, DEB + 1);
    end
    btn = 3'b111;
    idle(10);
  endtask

  task automatic test_random(input int cycles);
    int rem[NB];
    for (int i = 0; i < NB; i++) rem[i] = $urandom_range(1, 14);
    for (int k = 0; k < cycles; k++) begin
      for (int i = 0; i < NB; i++) begin
        if (rem[i] == 0) begin
          btn[i] = ~btn[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 30) : $urandom_range(1, 8);
        end else begin
          rem[i] = rem[i] - 1;
        end
      end
      tick();
    end
    btn = 3'b111;
    idle(25);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press(1'b0);
    test_long_press(1'b1);
    test_reset_mid_press();
    test_simultaneous();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw DE2 push-buttons (reset, hit, stay) before they reach the game logic: 2-FF synchronization, per-channel debounce state machine, one-cycle press/release edge pulses and a long-press pulse. Sits directly upstream of the 2 kHz counter and the global FSM. Channel 0 (reset key) supplies the counter's `i_ResetDeb` (from `o_Level[0]`) and `i_ResetNeg` (from `o_Fall[0]`). All channels are independent and identical.

## Interface
- `N_BTN`, 3, number of button channels (bit 0 = reset key)
- `DEB_CYCLES`, 40, consecutive stable samples required to accept a level change (20 ms at 2 kHz); legal range ≥ 2
- `HOLD_CYCLES`, 4000, cycles a press must persist after acceptance before `o_Hold` fires (2 s); must be > `DEB_CYCLES`

- `clk_2K`  in  1  2 kHz clock; all logic on its rising edge
- `i_Rst_n`  in  1  reset, asynchronous, active-low
- `i_Btn`  in  `N_BTN`  raw key pins, asynchronous, pulled up (1 = released, 0 = pressed)
- `o_Level`  out  `N_BTN`  debounced pin level (1 = released, 0 = pressed)
- `o_Fall`  out  `N_BTN`  one-cycle pulse on accepted 1→0 (press)
- `o_Rise`  out  `N_BTN`  one-cycle pulse on accepted 0→1 (release)
- `o_Hold`  out  `N_BTN`  one-cycle pulse, once per press, after `HOLD_CYCLES`

## Operation
- **Reset values** (async on `i_Rst_n`=0):
  - sync FFs = 1, `o_Level` = all 1, `o_Fall`/`o_Rise`/`o_Hold` = 0
  - debounce and hold counters = 0, state = `REL`
- **Synchronizer:** `i_Btn[i]` → sync1 → sync2. Call sync2 `s`.
- **Per-channel FSM:**
  - `REL` (`o_Level`=1): `s`=0 → `CHK_PRESS`, debounce count = 1; else stay.
  - `CHK_PRESS`: while `s`=0, count increments. When `s`=0 and count = `DEB_CYCLES`−1 → `PRS`, `o_Level`←0, `o_Fall`←1, count←0, hold←0. If `s`=1 → `REL`, count←0, no output change.
  - `PRS` (`o_Level`=0): hold counter increments each cycle, saturating at `HOLD_CYCLES`. The edge where it goes `HOLD_CYCLES`−1 → `HOLD_CYCLES` asserts `o_Hold` (once per press). `s`=1 → `CHK_REL`, count = 1; hold counter keeps its value.
  - `CHK_REL`: mirror of `CHK_PRESS`.
    - When `s`=1 and count = `DEB_CYCLES`−1 → `REL`, `o_Level`←1, `o_Rise`←1, count←0, hold←0.
    - If `s`=0 → `PRS`, count←0. Hold counting resumes from its held value, and hold does not increment while in `CHK_REL`.
- **Counter widths:** debounce counter = ceil(log2(`DEB_CYCLES`+1)); hold counter = ceil(log2(`HOLD_CYCLES`+1)). No wrap-around; the hold counter saturates.
- **Pulses:** all pulses are registered and high for exactly one cycle. `o_Fall` and `o_Rise` are never high together on the same channel. `o_Hold` can never coincide with `o_Fall` because `HOLD_CYCLES` > 0.
- **Reset mid-operation:** the channel returns to `REL` immediately and any in-flight pulse is cleared. A key still held after `i_Rst_n` rises is re-accepted as a fresh press (`o_Fall` after full latency).
- **Channel independence:** simultaneous activity on different channels is processed independently; pulses on different bits may coincide.

## Timing
- Let edge E0 be the first rising edge that samples the new raw level. Assume the raw level stays stable afterwards.
  - sync2 shows the new level after E0+1.
  - `o_Level` changes and the edge pulse is high after edge E0+`DEB_CYCLES`+1.
  - Latency is `DEB_CYCLES`+2 edges; the default is 42 edges = 21 ms.
- Any bounce shorter than `DEB_CYCLES` consecutive samples causes no output change.
- `o_Hold` is high after the `HOLD_CYCLES`-th edge following the `o_Fall` edge, provided there is no intervening accepted release.
- No combinational path from input to output.

## Test plan
Bench overrides: `DEB_CYCLES`=4, `HOLD_CYCLES`=10, `N_BTN`=3.
- **Reset:** hold `i_Rst_n`=0 with `i_Btn`=3'b000 → `o_Level`=3'b111 and all pulses 0 throughout.
- **Clean press/release:** after reset, drive `i_Btn[1]` 1→0 before edge E0.
  - `o_Level[1]` goes to 0 and `o_Fall[1]`=1 for exactly one cycle, after edge E0+5.
  - On release, `o_Rise[1]` pulses once with the same 6-edge latency.
- **Bounce rejection:**
  - Toggle `i_Btn[0]` low 3 cycles / high 1 / low 2 / high → `o_Level[0]` stays 1, no pulses.
  - Then low for ≥4 cycles → a single `o_Fall[0]`.
- **Long press:** hold `i_Btn[2]`=0 for 30 cycles.
  - `o_Hold[2]` pulses exactly once, 10 edges after `o_Fall[2]`, with no repeat.
  - Repeat with a 2-cycle release glitch at hold count 5 → `o_Hold` still fires once, 2 cycles later than in the glitch-free case.
- **Reset mid-press:**
  - With `o_Level[0]`=0 and `i_Btn[0]` still low, pulse `i_Rst_n` low for 1 cycle → `o_Level[0]`=1 asynchronously.
  - After release of `i_Rst_n`, `o_Fall[0]` pulses after 6 edges.
- **Simultaneous:** press `i_Btn[0]` and `i_Btn[2]` on the same edge → `o_Fall`=3'b101 in a single cycle; `o_Level[1]` is unaffected.
